// File: rtl/pixel_fetch_pkg.sv
// ============================================================================
// pixel_fetch_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the pixel fetch block: address/data width
//           constants, the layout of the upstream address word, the default
//           background colour and the fetch FSM state encoding.
// Ports   : none (package)
// ============================================================================
package pixel_fetch_pkg;

    // Pixel memory address width and pixel data width
    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    // Upstream address word: {valid, address}
    localparam int IN_W = ADDR_W + 1;

    // Underrun counter width
    localparam int UNDERRUN_W = 16;

    // Colour substituted for words whose valid flag is clear
    localparam logic [DATA_W-1:0] BG_COLOUR_DEFAULT = 16'h0000;

    // Upstream address word layout (bit 19 = valid, bits 18:0 = address)
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } addr_word_t;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_POP       = 2'd1,
        ST_REQ       = 2'd2,
        ST_WAIT_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_fetch_buf.sv
// ============================================================================
// pixel_fetch_buf
// ----------------------------------------------------------------------------
// Purpose : Synchronous show-ahead FIFO holding fetched pixels for the display.
//           The head entry is kept in an output register so it is valid in
//           the same cycle the FIFO reports not-empty, and it keeps its last
//           value once the FIFO runs dry.
// Ports   :
//   CLK        in   clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   wr_en_i    in   write one word
//   wr_data_i  in   word to write
//   rd_en_i    in   pop the head word (ignored while empty)
//   rd_data_o  out  head word (show-ahead)
//   empty_o    out  FIFO empty
//   count_o    out  occupancy, 0..DEPTH
// ============================================================================
module pixel_fetch_buf
    import pixel_fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_W
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [CNT_W-1:0] remain;
    logic             do_wr;
    logic             do_rd;

    // The fetch side never writes into a full buffer; the guard only keeps a
    // misbehaving writer from corrupting stored pixels.
    assign do_wr = wr_en_i && (count_q != CNT_W'(DEPTH));
    assign do_rd = rd_en_i && (count_q != '0);

    // Entries already stored that survive this cycle's pop
    assign remain = count_q - CNT_W'(do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Next head: an already stored entry if one survives, otherwise the
        // word being written now (bypass), otherwise hold the last value.
        if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (do_wr) begin
            head_d = wr_data_i;
        end
    end

    // Storage array: no reset, written only
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign rd_data_o = head_q;
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/pixel_fetch.sv
// ============================================================================
// pixel_fetch
// ----------------------------------------------------------------------------
// Purpose : Pops pixel addresses from an upstream show-ahead FIFO, reads the
//           pixel from memory (one read outstanding at most) and pushes the
//           result into an output pixel FIFO for the display. Words whose
//           valid flag is clear produce BG_COLOUR without a memory access.
//           Pixel order out always matches address order in.
// Config  : `define PIXEL_FETCH_UNDERRUN_EN to count display reads made
//           while the output buffer is empty (saturating). Without it the
//           counter output is tied to zero.
// Ports   :
//   CLK            in   clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   iADDRESS       in   [19] valid, [18:0] pixel address (upstream head)
//   iREADY_N       in   upstream FIFO empty (low = word available)
//   oREAD          out  one-cycle pop of the upstream FIFO
//   oMEM_ADDR      out  memory read address
//   oMEM_RD        out  memory read request, held until accepted
//   iMEM_WAIT      in   memory stall
//   iMEM_DATA      in   memory read data
//   iMEM_RVALID    in   iMEM_DATA valid
//   iDISP_RD       in   display pops one pixel
//   oPIXEL         out  head of output buffer (show-ahead)
//   oEMPTY         out  output buffer empty
//   oUNDERRUN_CNT  out  display reads seen while empty
// ============================================================================
module pixel_fetch
    import pixel_fetch_pkg::*;
#(
    parameter int                OUT_DEPTH = 8,
    parameter logic [DATA_W-1:0] BG_COLOUR = BG_COLOUR_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [IN_W-1:0]       iADDRESS,
    input  logic                  iREADY_N,
    output logic                  oREAD,
    output logic [ADDR_W-1:0]     oMEM_ADDR,
    output logic                  oMEM_RD,
    input  logic                  iMEM_WAIT,
    input  logic [DATA_W-1:0]     iMEM_DATA,
    input  logic                  iMEM_RVALID,
    input  logic                  iDISP_RD,
    output logic [DATA_W-1:0]     oPIXEL,
    output logic                  oEMPTY,
    output logic [UNDERRUN_W-1:0] oUNDERRUN_CNT
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              bg_wr_q, bg_wr_d;

    addr_word_t        in_word;
    logic [CNT_W-1:0]  occupancy;
    logic              room;
    logic              buf_wr;
    logic [DATA_W-1:0] buf_wdata;

    assign in_word = addr_word_t'(iADDRESS);

    // Free-slot check, only consulted in IDLE. There the only pixel that can
    // be on its way into the buffer is a pending background write, so
    // occupancy plus that write must leave at least one slot.
    assign room = ({1'b0, occupancy} + SUM_W'(bg_wr_q)) < SUM_W'(OUT_DEPTH);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bg_wr_d   = 1'b0;
        oREAD     = 1'b0;
        oMEM_RD   = 1'b0;
        // A background write (registered out of POP) can never coincide with
        // a memory write, because WAIT_DATA is not reachable from POP->IDLE.
        buf_wr    = bg_wr_q;
        buf_wdata = BG_COLOUR;

        case (state_q)
            ST_IDLE: begin
                if (!iREADY_N && room) begin
                    state_d = ST_POP;
                end
            end

            ST_POP: begin
                // Upstream is show-ahead: the word is on iADDRESS now
                oREAD  = 1'b1;
                addr_d = in_word.addr;
                if (in_word.valid) begin
                    state_d = ST_REQ;
                end else begin
                    bg_wr_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                oMEM_RD = 1'b1;
                if (!iMEM_WAIT) begin
                    state_d = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                if (iMEM_RVALID) begin
                    buf_wr    = 1'b1;
                    buf_wdata = iMEM_DATA;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset drops any outstanding read; iMEM_RVALID is only looked at in
    // WAIT_DATA so a late response after reset is discarded.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            bg_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bg_wr_q <= bg_wr_d;
        end
    end

    assign oMEM_ADDR = addr_q;

    pixel_fetch_buf #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DATA_W)
    ) u_buf (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .wr_en_i   (buf_wr),
        .wr_data_i (buf_wdata),
        .rd_en_i   (iDISP_RD),
        .rd_data_o (oPIXEL),
        .empty_o   (oEMPTY),
        .count_o   (occupancy)
    );

`ifdef PIXEL_FETCH_UNDERRUN_EN
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (iDISP_RD && oEMPTY && (underrun_q != '1)) begin
            underrun_d = underrun_q + UNDERRUN_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign oUNDERRUN_CNT = underrun_q;
`else
    assign oUNDERRUN_CNT = '0;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
`timescale 1ns/1ps
module tb_pixel_fetch;

    localparam int          DEPTH = 8;
    localparam logic [15:0] BG    = 16'h1234;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [19:0] iADDRESS = 20'h0;
    logic        iREADY_N = 1'b1;
    logic        oREAD;
    logic [18:0] oMEM_ADDR;
    logic        oMEM_RD;
    logic        iMEM_WAIT = 1'b0;
    logic [15:0] iMEM_DATA = 16'h0;
    logic        iMEM_RVALID = 1'b0;
    logic        iDISP_RD = 1'b0;
    logic [15:0] oPIXEL;
    logic        oEMPTY;
    logic [15:0] oUNDERRUN_CNT;

    pixel_fetch #(
        .OUT_DEPTH (DEPTH),
        .BG_COLOUR (BG)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .iADDRESS      (iADDRESS),
        .iREADY_N      (iREADY_N),
        .oREAD         (oREAD),
        .oMEM_ADDR     (oMEM_ADDR),
        .oMEM_RD       (oMEM_RD),
        .iMEM_WAIT     (iMEM_WAIT),
        .iMEM_DATA     (iMEM_DATA),
        .iMEM_RVALID   (iMEM_RVALID),
        .iDISP_RD      (iDISP_RD),
        .oPIXEL        (oPIXEL),
        .oEMPTY        (oEMPTY),
        .oUNDERRUN_CNT (oUNDERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Scoreboards and upstream FIFO model
    logic [19:0] up_q[$];
    logic [15:0] sb_q[$];
    logic [18:0] exp_addr_q[$];

    // Values seen at the previous negedge (in effect at the posedge since)
    logic        p_read = 1'b0;
    logic        p_memrd = 1'b0;
    logic        p_wait = 1'b0;
    logic [18:0] p_memaddr = 19'h0;

    // Memory model
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [18:0] mem_paddr = 19'h0;
    int          lat_min = 2;
    int          lat_max = 2;
    int          wait_pct = 0;
    logic        force_wait = 1'b0;
    logic        inject_rvalid = 1'b0;

    // Display model
    logic        disp_en = 1'b0;
    int          disp_pct = 100;
    logic        force_disp = 1'b0;
    logic [15:0] last_pix = 16'h0;

    int n_reads = 0;
    int n_accepts = 0;
    int n_memrd_cycles = 0;

    function automatic logic [15:0] mem_f(input logic [18:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {13'b0, a[18:16]};
    endfunction

    // One clock of all models: account for the posedge just passed, then
    // drive inputs for the next one.
    task automatic tick();
        logic [18:0] ea;
        logic [15:0] ep;
        logic [19:0] popped;
        @(negedge CLK);
        if (p_read) begin
            n_reads++;
            if (up_q.size() > 0) begin
                popped = up_q.pop_front();
                $display("upstream pop %h", popped);
            end
        end
        if (p_memrd) n_memrd_cycles++;
        if (p_memrd && !p_wait) begin
            n_accepts++;
            total++;
            if (exp_addr_q.size() == 0) begin
                $display("FAIL mem_addr: unexpected read at %h, required no read", p_memaddr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (p_memaddr !== ea)
                    $display("FAIL mem_addr: got %h required %h", p_memaddr, ea);
                else begin
                    passed++;
                    $display("mem read %h", p_memaddr);
                end
            end
            mem_pend  = 1'b1;
            mem_cnt   = int'($urandom_range(lat_max, lat_min));
            mem_paddr = p_memaddr;
        end

        iMEM_RVALID = 1'b0;
        iMEM_DATA   = 16'h0;
        if (inject_rvalid) begin
            iMEM_RVALID   = 1'b1;
            iMEM_DATA     = 16'hDEAD;
            inject_rvalid = 1'b0;
        end else if (mem_pend) begin
            if (mem_cnt <= 1) begin
                iMEM_RVALID = 1'b1;
                iMEM_DATA   = mem_f(mem_paddr);
                mem_pend    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        iMEM_WAIT = force_wait || (int'($urandom_range(0, 99)) < wait_pct);

        iREADY_N = (up_q.size() == 0);
        iADDRESS = (up_q.size() > 0) ? up_q[0] : 20'h0;

        iDISP_RD = 1'b0;
        if (force_disp) begin
            iDISP_RD = 1'b1;
        end else if (disp_en && !oEMPTY && (int'($urandom_range(0, 99)) < disp_pct)) begin
            iDISP_RD = 1'b1;
            total++;
            if (sb_q.size() == 0) begin
                $display("FAIL pixel: got extra pixel %h, required none", oPIXEL);
            end else begin
                ep = sb_q.pop_front();
                if (oPIXEL !== ep)
                    $display("FAIL pixel: got %h required %h", oPIXEL, ep);
                else begin
                    passed++;
                    $display("pixel %h", oPIXEL);
                end
            end
            last_pix = oPIXEL;
        end

        p_read    = oREAD;
        p_memrd   = oMEM_RD;
        p_wait    = iMEM_WAIT;
        p_memaddr = oMEM_ADDR;
    endtask

    task automatic push_word(input logic [19:0] w);
        up_q.push_back(w);
        if (w[19]) begin
            exp_addr_q.push_back(w[18:0]);
            sb_q.push_back(mem_f(w[18:0]));
        end else begin
            sb_q.push_back(BG);
        end
        iREADY_N = 1'b0;
        iADDRESS = up_q[0];
    endtask

    // Run until every pushed word has come out of the display, bounded
    task automatic run_drain(input int budget, output logic ok);
        int n;
        n = 0;
        while ((up_q.size() != 0 || sb_q.size() != 0 || mem_pend) && n < budget) begin
            tick();
            n++;
        end
        ok = (up_q.size() == 0 && sb_q.size() == 0 && !mem_pend);
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (oREAD !== 1'b0) $display("FAIL reset_oread: got %b required 0", oREAD); else passed++;
        total++; if (oMEM_RD !== 1'b0) $display("FAIL reset_memrd: got %b required 0", oMEM_RD); else passed++;
        total++; if (oMEM_ADDR !== 19'h0) $display("FAIL reset_memaddr: got %h required 0", oMEM_ADDR); else passed++;
        total++; if (oEMPTY !== 1'b1) $display("FAIL reset_empty: got %b required 1", oEMPTY); else passed++;
        total++; if (oPIXEL !== 16'h0) $display("FAIL reset_pixel: got %h required 0", oPIXEL); else passed++;
        total++; if (oUNDERRUN_CNT !== 16'h0) $display("FAIL reset_underrun: got %h required 0", oUNDERRUN_CNT); else passed++;
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int   n;
        logic ok;
        disp_en = 1'b0; lat_min = 1; lat_max = 1; wait_pct = 0;
        push_word(20'h80003);
        n = 0;
        while (oEMPTY && n < 50) begin
            tick();
            n++;
        end
        total++; if (n !== 4) $display("FAIL latency: got %0d cycles required 4", n); else passed++;
        disp_en = 1'b1; disp_pct = 100;
        run_drain(100, ok);
        total++; if (!ok) $display("FAIL latency_drain: got %0d pixels left required 0", sb_q.size()); else passed++;
    endtask

    task automatic test_order();
        int   a0;
        logic ok;
        disp_en = 1'b1; disp_pct = 100; lat_min = 2; lat_max = 2; wait_pct = 0;
        a0 = n_accepts;
        for (int i = 0; i < 3; i++) push_word({1'b1, 19'(i)});
        run_drain(200, ok);
        total++; if (!ok) $display("FAIL order_drain: got %0d pixels left required 0", sb_q.size()); else passed++;
        total++; if (n_accepts - a0 !== 3) $display("FAIL order_reads: got %0d required 3", n_accepts - a0); else passed++;
    endtask

    task automatic test_invalid();
        int   m0;
        logic ok;
        disp_en = 1'b1; disp_pct = 100;
        m0 = n_memrd_cycles;
        push_word(20'h00005);
        run_drain(100, ok);
        tick();
        total++; if (!ok) $display("FAIL invalid_drain: got %0d pixels left required 0", sb_q.size()); else passed++;
        total++; if (n_memrd_cycles - m0 !== 0) $display("FAIL invalid_memrd: got %0d cycles required 0", n_memrd_cycles - m0); else passed++;
    endtask

    task automatic test_wait();
        int   n;
        int   stable;
        int   a0;
        logic ok;
        disp_en = 1'b1; disp_pct = 100; lat_min = 1; lat_max = 1;
        force_wait = 1'b1;
        a0 = n_accepts;
        push_word(20'h80007);
        n = 0;
        while (!oMEM_RD && n < 20) begin
            tick();
            n++;
        end
        total++; if (oMEM_RD !== 1'b1) $display("FAIL wait_req: got %b required 1", oMEM_RD); else passed++;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (oMEM_RD === 1'b1 && oMEM_ADDR === 19'h7) stable++;
            tick();
        end
        total++; if (stable !== 10) $display("FAIL wait_stable: got %0d cycles required 10", stable); else passed++;
        force_wait = 1'b0;
        run_drain(100, ok);
        total++; if (!ok) $display("FAIL wait_drain: got %0d pixels left required 0", sb_q.size()); else passed++;
        total++; if (n_accepts - a0 !== 1) $display("FAIL wait_reads: got %0d required 1", n_accepts - a0); else passed++;
    endtask

    task automatic test_fill();
        int   r0;
        logic ok;
        disp_en = 1'b0; lat_min = 1; lat_max = 2; wait_pct = 0;
        r0 = n_reads;
        for (int i = 0; i < 12; i++) push_word({1'b1, 19'(16'h100 + i)});
        for (int i = 0; i < 120; i++) tick();
        total++; if (n_reads - r0 !== DEPTH) $display("FAIL fill_pops: got %0d required %0d", n_reads - r0, DEPTH); else passed++;
        total++; if (up_q.size() !== 12 - DEPTH) $display("FAIL fill_left: got %0d required %0d", up_q.size(), 12 - DEPTH); else passed++;
        total++; if (oREAD !== 1'b0) $display("FAIL fill_oread: got %b required 0", oREAD); else passed++;
        total++; if (oEMPTY !== 1'b0) $display("FAIL fill_empty: got %b required 0", oEMPTY); else passed++;
        disp_en = 1'b1; disp_pct = 100;
        run_drain(300, ok);
        total++; if (!ok) $display("FAIL fill_drain: got %0d pixels left required 0", sb_q.size()); else passed++;
    endtask

    task automatic test_underrun();
        logic [15:0] exp_u;
`ifdef PIXEL_FETCH_UNDERRUN_EN
        exp_u = 16'd3;
`else
        exp_u = 16'd0;
`endif
        for (int i = 0; i < 3; i++) tick();
        force_disp = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        force_disp = 1'b0;
        tick();
        total++; if (oUNDERRUN_CNT !== exp_u) $display("FAIL underrun_cnt: got %0d required %0d", oUNDERRUN_CNT, exp_u); else passed++;
        total++; if (oEMPTY !== 1'b1) $display("FAIL underrun_empty: got %b required 1", oEMPTY); else passed++;
        total++; if (oPIXEL !== last_pix) $display("FAIL underrun_hold: got %h required %h", oPIXEL, last_pix); else passed++;
    endtask

    task automatic test_back_to_back();
        int          a0;
        int          nvalid;
        logic [19:0] w;
        logic        ok;
        disp_en = 1'b1; disp_pct = 50; lat_min = 1; lat_max = 3; wait_pct = 30;
        a0 = n_accepts;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            w = {($urandom_range(0, 3) != 0), 19'($urandom)};
            if (w[19]) nvalid++;
            push_word(w);
            if ((i % 8) == 7) for (int k = 0; k < 20; k++) tick();
        end
        run_drain(4000, ok);
        total++; if (!ok) $display("FAIL b2b_drain: got %0d pixels left required 0", sb_q.size()); else passed++;
        total++; if (n_accepts - a0 !== nvalid) $display("FAIL b2b_reads: got %0d required %0d", n_accepts - a0, nvalid); else passed++;
        wait_pct = 0;
    endtask

    task automatic test_reset_mid();
        int a0;
        int n;
        disp_en = 1'b0; lat_min = 6; lat_max = 6; wait_pct = 0;
        a0 = n_accepts;
        push_word(20'h80009);
        n = 0;
        while (n_accepts == a0 && n < 30) begin
            tick();
            n++;
        end
        total++; if (n_accepts - a0 !== 1) $display("FAIL rstmid_accept: got %0d required 1", n_accepts - a0); else passed++;
        #2;
        RESET_N = 1'b0;
        #1;
        total++; if (oUNDERRUN_CNT !== 16'h0) $display("FAIL rstmid_underrun: got %h required 0", oUNDERRUN_CNT); else passed++;
        mem_pend = 1'b0;
        sb_q.delete();
        exp_addr_q.delete();
        p_read = 1'b0; p_memrd = 1'b0; p_wait = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        inject_rvalid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total++; if (oEMPTY !== 1'b1) $display("FAIL rstmid_empty: got %b required 1", oEMPTY); else passed++;
        total++; if (oMEM_RD !== 1'b0) $display("FAIL rstmid_memrd: got %b required 0", oMEM_RD); else passed++;
        total++; if (n_accepts - a0 !== 1) $display("FAIL rstmid_reads: got %0d required 1", n_accepts - a0); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_order();
        test_invalid();
        test_wait();
        test_fill();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
